// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller for the pipelined MIPS core: an EX..WB destination scoreboard drives stall, flush, ID bypass and registered EX forward selects.
// Build option: define HAZARD_SCOREBOARD_FWD_EN to enable EX forwarding (only load-use then stalls).
module hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [REG_AW-1:0]          id_rs,
  input  logic [REG_AW-1:0]          id_rt,
  input  logic                       id_rs_used,
  input  logic                       id_rt_used,
  input  logic                       id_we,
  input  logic [REG_AW-1:0]          id_dest,
  input  logic                       id_is_load,
  input  logic                       ex_branch_taken,
  output logic                       pc_hold,
  output logic                       ifid_hold,
  output logic                       ifid_flush,
  output logic                       idex_bubble,
  output logic                       id_byp_a,
  output logic                       id_byp_b,
  output logic [$clog2(DEPTH)-1:0]   ex_fwd_a,
  output logic [$clog2(DEPTH)-1:0]   ex_fwd_b,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int FW = $clog2(DEPTH);

  logic [DEPTH-1:0]  v_q, v_d;
  logic [REG_AW-1:0] dst_q [DEPTH];
  logic [REG_AW-1:0] dst_d [DEPTH];
  logic [FW-1:0]     ex_fwd_a_q, ex_fwd_a_d, ex_fwd_b_q, ex_fwd_b_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [DEPTH-1:0]  match_a_s, match_b_s;
  logic              hazard_s, stall_s, flush_s;

`ifdef HAZARD_SCOREBOARD_FWD_EN
  // Only entries below LOAD_STAGE need the load flag.
  logic [LOAD_STAGE-1:0] ld_q, ld_d;

  // Youngest matching entry in EX..MEM wins; code is entry index + 1.
  function automatic logic [FW-1:0] fwd_code(input logic [DEPTH-1:0] m);
    logic [FW-1:0] c;
    c = {FW{1'b0}};
    for (int k = DEPTH - 2; k >= 0; k--) begin
      c = m[k] ? FW'(k + 1) : c;
    end
    return c;
  endfunction
`else
  logic unused_load_s;
  assign unused_load_s = id_is_load;
`endif

  // Source-versus-entry compare; register 0 never matches.
  always_comb begin
    match_a_s = {DEPTH{1'b0}};
    match_b_s = {DEPTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      match_a_s[k] = id_valid & id_rs_used & v_q[k] & (dst_q[k] == id_rs) & (id_rs != {REG_AW{1'b0}});
      match_b_s[k] = id_valid & id_rt_used & v_q[k] & (dst_q[k] == id_rt) & (id_rt != {REG_AW{1'b0}});
    end
  end

  // Hazard detection, then stall/flush qualification (flush wins, reset masks both).
  always_comb begin
    hazard_s = 1'b0;
`ifdef HAZARD_SCOREBOARD_FWD_EN
    for (int k = 0; k < LOAD_STAGE; k++) begin
      hazard_s = hazard_s | (ld_q[k] & (match_a_s[k] | match_b_s[k]));
    end
`else
    for (int k = 0; k < DEPTH - 1; k++) begin
      hazard_s = hazard_s | match_a_s[k] | match_b_s[k];
    end
`endif
    flush_s = ex_branch_taken & ~rst;
    stall_s = hazard_s & ~ex_branch_taken & ~rst;
  end

  assign pc_hold     = stall_s;
  assign ifid_hold   = stall_s;
  assign ifid_flush  = flush_s;
  assign idex_bubble = stall_s | flush_s;
  assign id_byp_a    = match_a_s[DEPTH-1];
  assign id_byp_b    = match_b_s[DEPTH-1];
  assign ex_fwd_a    = ex_fwd_a_q;
  assign ex_fwd_b    = ex_fwd_b_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

  // Next-state: scoreboard shift, forward selects, saturating counters.
  always_comb begin
    v_d[0]   = id_valid & id_we & ~stall_s & ~flush_s;
    dst_d[0] = (stall_s | flush_s) ? {REG_AW{1'b0}} : id_dest;
    for (int k = 1; k < DEPTH; k++) begin
      v_d[k]   = v_q[k-1];
      dst_d[k] = dst_q[k-1];
    end
`ifdef HAZARD_SCOREBOARD_FWD_EN
    ld_d[0] = id_is_load & ~stall_s & ~flush_s;
    for (int k = 1; k < LOAD_STAGE; k++) begin
      ld_d[k] = ld_q[k-1];
    end
    ex_fwd_a_d = (stall_s | flush_s) ? {FW{1'b0}} : fwd_code(match_a_s);
    ex_fwd_b_d = (stall_s | flush_s) ? {FW{1'b0}} : fwd_code(match_b_s);
`else
    ex_fwd_a_d = {FW{1'b0}};
    ex_fwd_b_d = {FW{1'b0}};
`endif
    stall_cnt_d = (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush_s && (flush_cnt_q != {CNT_W{1'b1}})) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        dst_q[k] <= {REG_AW{1'b0}};
      end
`ifdef HAZARD_SCOREBOARD_FWD_EN
      ld_q <= {LOAD_STAGE{1'b0}};
`endif
      ex_fwd_a_q  <= {FW{1'b0}};
      ex_fwd_b_q  <= {FW{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      v_q <= v_d;
      for (int k = 0; k < DEPTH; k++) begin
        dst_q[k] <= dst_d[k];
      end
`ifdef HAZARD_SCOREBOARD_FWD_EN
      ld_q <= ld_d;
`endif
      ex_fwd_a_q  <= ex_fwd_a_d;
      ex_fwd_b_q  <= ex_fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the pipelined MIPS core. It sits beside the ID stage and tracks in-flight destination registers in a shift-register scoreboard, one entry per stage from EX to WB. Each cycle it decides to stall, bubble or flush, and issues registered forwarding selects that travel with the instruction into EX. It replaces the current free-running pipeline registers (`ld_i` = 1, `clear_i` = 0), which have no stall, flush or forwarding control.

## Interface

Parameters:
- `REG_AW`, default 5: register-address width.
- `DEPTH`, default 3: scoreboard entries. Entry 0 is EX, entry `DEPTH-1` is WB. Must be 2 or more.
- `LOAD_STAGE`, default 1: the lowest entry index whose load result is forwardable. Must satisfy 1 ≤ `LOAD_STAGE` ≤ `DEPTH-1`.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous reset, active-high.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs` / `id_rt` in `REG_AW`: ID source registers.
- `id_rs_used` / `id_rt_used` in 1: the source is actually read.
- `id_we` in 1: the ID instruction writes a register.
- `id_dest` in `REG_AW`: destination register of the ID instruction.
- `id_is_load` in 1: the ID instruction is a load.
- `ex_branch_taken` in 1: a branch resolved taken in EX this cycle.
- `pc_hold` out 1: hold the PC.
- `ifid_hold` out 1: hold IF/ID.
- `ifid_flush` out 1: clear IF/ID.
- `idex_bubble` out 1: load a bubble into ID/EX.
- `id_byp_a` / `id_byp_b` out 1: at ID, select WB write data instead of the regfile read.
- `ex_fwd_a` / `ex_fwd_b` out `$clog2(DEPTH)`: forward select for the instruction in EX.
- `stall_cnt` / `flush_cnt` out `CNT_W`: saturating event counters.

## Operation

- **Scoreboard entry contents:** {v, ld, dst}. An entry whose `dst` is 0 never matches anything.
- **Match definition:** source s matches entry k when `id_valid`, the source's `*_used` bit, `sb[k].v` and `sb[k].dst` = s all hold, and s ≠ 0.
- **Hazard (with `FWD_EN`):** a source matches entry k with `sb[k].ld` = 1 and k < `LOAD_STAGE`.
- **Hazard (without `FWD_EN`):** a source matches any k ≤ `DEPTH-2`.
- **Stall:** hazard present and `ex_branch_taken` = 0.
  - Outputs: `pc_hold` = `ifid_hold` = `idex_bubble` = 1.
- **Flush:** `ex_branch_taken` = 1. Flush overrides stall.
  - Outputs: `ifid_flush` = `idex_bubble` = 1, `pc_hold` = `ifid_hold` = 0.
- **Scoreboard shift, every cycle:**
  - `sb[k]` <= `sb[k-1]` for k ≥ 1.
  - `sb[0]` <= {`id_valid` & `id_we`, `id_is_load`, `id_dest`} when neither stall nor flush is active; otherwise `sb[0]` <= 0.
- **`ex_fwd_a` / `ex_fwd_b` (registered):**
  - Computed from the youngest (lowest k ≤ `DEPTH-2`) matching entry. The value is k+1, or 0 if there is no match.
  - Forced to 0 on stall, on flush, or when `FWD_EN` is undefined.
  - Code c selects the pipeline register after stage c+1 (1 = EX/MEM, 2 = MEM/WB for `DEPTH` = 3).
- **`id_byp_a` / `id_byp_b` (combinational):** asserted when the source matches entry `DEPTH-1`. This applies in both builds and covers the regfile write-after-read gap.
- **Counters:** `stall_cnt` +1 per stall cycle, `flush_cnt` +1 per flush cycle. Both saturate at all-ones.

## Timing

- **Reset:** `rst` asynchronously clears all entries, both `ex_fwd` outputs and both counters.
  - All combinational outputs are 0 while in reset, since the scoreboard is empty and flush/stall are gated by `rst`.
- **Latency:**
  - `pc_hold`, `ifid_hold`, `ifid_flush`, `idex_bubble` and `id_byp_*` are combinational, valid in the same cycle as their inputs.
  - `ex_fwd_*` is valid one cycle after ID, together with the instruction in EX.
- **Load-use (`DEPTH` = 3, `LOAD_STAGE` = 1):** exactly 1 stall cycle, then `ex_fwd` = 2.
- **No-forward build:** maximum stall is `DEPTH-1` cycles.
- **Stall persistence:** a stall needs no handshake; it persists while the hazard exists and self-clears because bubbles drain the scoreboard.
- **Branch during a stall:** the flush takes effect and the stalled ID instruction is discarded.
- **Reset mid-stall:** all holds deassert immediately.

## Configuration

- `HAZARD_SCOREBOARD_FWD_EN` defined:
  - `ex_fwd_*` is driven.
  - Only load-use hazards (k < `LOAD_STAGE`) stall.
- `HAZARD_SCOREBOARD_FWD_EN` undefined:
  - `ex_fwd_*` is tied to 0.
  - Any match in entries 0..`DEPTH-2` stalls; the datapath reads the regfile or uses `id_byp` only.

## Test plan

- **ALU-to-ALU dependency:** `add $3` then `sub` reading `$3` back-to-back, FWD_EN build → no stall, `ex_fwd_a` = 1 in the next cycle; with one gap instruction → `ex_fwd_a` = 2.
- **Load-use:** `lw $5` then `add` reading `$5` → `pc_hold`, `ifid_hold` and `idex_bubble` high for 1 cycle, `stall_cnt` = 1, then `ex_fwd` = 2.
- **Branch during load stall:** `ex_branch_taken` = 1 in the same cycle as a load-use hazard → `ifid_flush` = 1, `pc_hold` = 0, `flush_cnt` = 1, `stall_cnt` unchanged, entry 0 cleared.
- **WB bypass and `$0`:** producer of `$7` reaches entry 2 while ID reads `$7` → `id_byp_a` = 1; dest `$0` → never stalls, bypasses or forwards.
- **No-forward build:** `add $3` then a dependent instruction with FWD_EN undefined → 2 stall cycles, then `id_byp` = 1, `ex_fwd` = 0 throughout.
- **Reset mid-stall:** `rst` pulse during a load-use stall → all outputs 0 immediately, counters 0, the first instruction after reset issues with no stall.
